// File: rtl/pp_acc_pkg.sv
// Shared constants for the partial-product column accumulator: column geometry,
// widths, FSM encoding and the per-beat framing struct.
package pp_acc_pkg;

    localparam int NUM_LANES = 9;
    localparam int NUM_COLS  = 16;
    localparam int DOT_W     = 19;
    localparam int POP_W     = 6;

    localparam logic [DOT_W-1:0] CORR_DEFAULT = 19'h1D000;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ACCUM = 1'b1;

    typedef struct packed {
        logic first;
        logic last;
    } beat_ctl_t;

    // Rows per column in each lane of the upstream multiplier (column 0..15).
    function automatic int col_rows(input int k);
        case (k)
            0: return 2;   1: return 1;   2: return 3;   3: return 2;
            4: return 4;   5: return 3;   6: return 5;   7: return 4;
            8: return 4;   9: return 4;  10: return 4;  11: return 4;
           12: return 2;  13: return 2;  14: return 1;  15: return 1;
            default: return 0;
        endcase
    endfunction

    // Bit offset of column k inside the flattened {O15..O0} bundle.
    function automatic int col_off(input int k);
        int off;
        off = 0;
        for (int i = 0; i < k; i++) off += NUM_LANES * col_rows(i);
        return off;
    endfunction

    localparam int COLS_W = col_off(NUM_COLS);

endpackage

// File: rtl/pp_column_accumulator_col_popcount.sv
// Population count of one partial-product column across all lanes.
module col_popcount
    import pp_acc_pkg::*;
#(
    parameter int ROWS = 1
) (
    input  logic [NUM_LANES*ROWS-1:0] bits,
    output logic [POP_W-1:0]          count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < NUM_LANES * ROWS; i++) count = count + POP_W'(bits[i]);
    end

endmodule

// File: rtl/pp_column_accumulator.sv
// Column popcount -> weighted dot product -> framed saturating accumulator.
// Three register stages, one beat per clock, no backpressure.
module pp_column_accumulator
    import pp_acc_pkg::*;
#(
    parameter int               ACC_W = 24,
    parameter logic [DOT_W-1:0] CORR  = CORR_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic                    in_first,
    input  logic                    in_last,
    input  logic [8:0]              O15,
    input  logic [8:0]              O14,
    input  logic [17:0]             O13,
    input  logic [17:0]             O12,
    input  logic [35:0]             O11,
    input  logic [35:0]             O10,
    input  logic [35:0]             O9,
    input  logic [35:0]             O8,
    input  logic [35:0]             O7,
    input  logic [44:0]             O6,
    input  logic [26:0]             O5,
    input  logic [35:0]             O4,
    input  logic [17:0]             O3,
    input  logic [26:0]             O2,
    input  logic [8:0]              O1,
    input  logic [17:0]             O0,
    output logic                    out_valid,
    output logic signed [ACC_W-1:0] out_data,
    output logic                    out_sat,
    output logic                    seq_err
);

    localparam int STAGES = 2;

    logic [COLS_W-1:0]                  cols;
    logic [NUM_COLS-1:0][POP_W-1:0]     pop_d, pop_q;
    logic [STAGES-1:0]                  vld_pipe;
    beat_ctl_t [STAGES-1:0]             ctl_pipe;
    logic [DOT_W-1:0]                   dot_d;
    logic signed [DOT_W-1:0]            dot_q;

    assign cols = {O15, O14, O13, O12, O11, O10, O9, O8, O7, O6, O5, O4, O3, O2, O1, O0};

    for (genvar k = 0; k < NUM_COLS; k++) begin : g_col
        col_popcount #(.ROWS(col_rows(k))) u_pop (
            .bits  (cols[col_off(k) +: NUM_LANES*col_rows(k)]),
            .count (pop_d[k])
        );
    end

    // Sum wraps modulo 2^DOT_W; CORR folds the sign-extension bits back in.
    always_comb begin
        dot_d = CORR;
        for (int k = 0; k < NUM_COLS; k++) dot_d = dot_d + (DOT_W'(pop_q[k]) << k);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_pipe <= '0;
            ctl_pipe <= '0;
            pop_q    <= '0;
            dot_q    <= '0;
        end else begin
            vld_pipe <= {vld_pipe[0], in_valid};
            ctl_pipe <= {ctl_pipe[0], beat_ctl_t'{first: in_first, last: in_last}};
            if (in_valid)    pop_q <= pop_d;
            if (vld_pipe[0]) dot_q <= dot_d;
        end
    end

    logic [0:0]              state;
    logic signed [ACC_W-1:0] acc, acc_n;
    logic                    sat, sat_n;
    logic                    restart, frame_err, ovf;
    logic [ACC_W:0]          base, dot_x, sum;

    // A beat without first in IDLE, or with first in ACCUM, is a framing error;
    // both cases restart the accumulation from this beat.
    always_comb begin
        restart   = ctl_pipe[1].first || (state == ST_IDLE);
        frame_err = ctl_pipe[1].first == (state == ST_ACCUM);
        dot_x     = {{(ACC_W+1-DOT_W){dot_q[DOT_W-1]}}, dot_q};
        base      = restart ? '0 : {acc[ACC_W-1], acc};
        sum       = base + dot_x;
        ovf       = sum[ACC_W] ^ sum[ACC_W-1];
        if (!ovf)            acc_n = sum[ACC_W-1:0];
        else if (sum[ACC_W]) acc_n = {1'b1, {(ACC_W-1){1'b0}}};
        else                 acc_n = {1'b0, {(ACC_W-1){1'b1}}};
        sat_n     = ovf | (sat & ~restart);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            acc       <= '0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            seq_err   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            seq_err   <= 1'b0;
            if (vld_pipe[1]) begin
                seq_err <= frame_err;
                acc     <= acc_n;
                sat     <= sat_n;
                if (ctl_pipe[1].last) begin
                    out_valid <= 1'b1;
                    out_data  <= acc_n;
                    out_sat   <= sat_n;
                    state     <= ST_IDLE;
                end else begin
                    state     <= ST_ACCUM;
                end
            end
        end
    end

endmodule

// File: tb/tb_pp_column_accumulator.sv
// Bench: emulates the upstream multiplier column bundles from lane operand pairs
// and checks two accumulator widths against a frame-level reference model.
module tb_pp_column_accumulator;

    localparam int ROWS [16] = '{2, 1, 3, 2, 4, 3, 5, 4, 4, 4, 4, 4, 2, 2, 1, 1};
    localparam int W [2]     = '{24, 20};

    typedef struct { bit vld; longint data; bit sat; bit err; } exp_t;
    typedef struct { longint data; bit sat; } got_t;
    typedef struct { int a; int b; longint exp; } vec_t;

    logic clk;
    logic reset;
    logic in_valid, in_first, in_last;
    logic [44:0] col [16];
    logic [8:0]  O15, O14, O1;
    logic [17:0] O13, O12, O3, O0;
    logic [35:0] O11, O10, O9, O8, O7, O4;
    logic [44:0] O6;
    logic [26:0] O5, O2;
    logic               ov24, os24, oe24, ov20, os20, oe20;
    logic signed [23:0] od24;
    logic signed [19:0] od20;

    assign O0  = col[0][17:0];   assign O1  = col[1][8:0];
    assign O2  = col[2][26:0];   assign O3  = col[3][17:0];
    assign O4  = col[4][35:0];   assign O5  = col[5][26:0];
    assign O6  = col[6][44:0];   assign O7  = col[7][35:0];
    assign O8  = col[8][35:0];   assign O9  = col[9][35:0];
    assign O10 = col[10][35:0];  assign O11 = col[11][35:0];
    assign O12 = col[12][17:0];  assign O13 = col[13][17:0];
    assign O14 = col[14][8:0];   assign O15 = col[15][8:0];

    pp_column_accumulator #(.ACC_W(24)) u_dut24 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
        .O15(O15), .O14(O14), .O13(O13), .O12(O12), .O11(O11), .O10(O10), .O9(O9), .O8(O8),
        .O7(O7), .O6(O6), .O5(O5), .O4(O4), .O3(O3), .O2(O2), .O1(O1), .O0(O0),
        .out_valid(ov24), .out_data(od24), .out_sat(os24), .seq_err(oe24)
    );

    pp_column_accumulator #(.ACC_W(20)) u_dut20 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
        .O15(O15), .O14(O14), .O13(O13), .O12(O12), .O11(O11), .O10(O10), .O9(O9), .O8(O8),
        .O7(O7), .O6(O6), .O5(O5), .O4(O4), .O3(O3), .O2(O2), .O1(O1), .O0(O0),
        .out_valid(ov20), .out_data(od20), .out_sat(os20), .seq_err(oe20)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     n_vec = 0, n_err = 0, cyc = 0;
    int     la [9], lb [9];
    exp_t   ep [2][3];
    longint m_acc [2], m_hold [2];
    bit     m_in [2], m_sat [2];
    got_t   got_q [2][$];
    int     n_errp [2];

    task automatic chk(input string nm, input int d, input longint got, input longint want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s acc%0d @cycle %0d: got %0d, want %0d", nm, W[d], cyc, got, want);
        end
    endtask

    task automatic bcast(input int a, input int b);
        for (int i = 0; i < 9; i++) begin la[i] = a; lb[i] = b; end
    endtask

    // Each lane contributes a*b + 45056 as weighted column bits; 9*45056 cancels CORR mod 2^19.
    task automatic build(input bit noise);
        int v, c, r;
        for (int k = 0; k < 16; k++) col[k] = noise ? 45'({$urandom, $urandom}) : '0;
        if (!noise) begin
            for (int i = 0; i < 9; i++) begin
                v = la[i] * lb[i] + 45056;
                for (int k = 15; k >= 0; k--) begin
                    c = v >> k;
                    if (c > ROWS[k]) c = ROWS[k];
                    v -= c << k;
                    r = $urandom_range(ROWS[k] - 1);
                    for (int j = 0; j < c; j++) col[k][i*ROWS[k] + (j + r) % ROWS[k]] = 1'b1;
                end
            end
        end
    endtask

    task automatic model_beat(input bit v, input bit f, input bit l);
        longint dot, a, lo, hi;
        bit     s;
        exp_t   e;
        dot = 0;
        for (int i = 0; i < 9; i++) dot += longint'(la[i] * lb[i]);
        for (int d = 0; d < 2; d++) begin
            hi = (longint'(1) << (W[d] - 1)) - 1;
            lo = -(longint'(1) << (W[d] - 1));
            e = '{vld: 1'b0, data: m_hold[d], sat: 1'b0, err: 1'b0};
            if (v) begin
                e.err = (f == m_in[d]);
                if (f || !m_in[d]) begin a = dot; s = 1'b0; end
                else begin a = m_acc[d] + dot; s = m_sat[d]; end
                if (a > hi) begin a = hi; s = 1'b1; end
                else if (a < lo) begin a = lo; s = 1'b1; end
                if (l) begin
                    e.vld = 1'b1; e.data = a; e.sat = s;
                    m_hold[d] = a; m_in[d] = 1'b0;
                end else begin
                    m_acc[d] = a; m_sat[d] = s; m_in[d] = 1'b1;
                end
            end
            ep[d][2] = ep[d][1]; ep[d][1] = ep[d][0]; ep[d][0] = e;
        end
    endtask

    task automatic check_outputs();
        for (int d = 0; d < 2; d++) begin
            bit ov, os, oe;
            longint od;
            if (d == 0) begin ov = ov24; os = os24; oe = oe24; od = longint'(od24); end
            else        begin ov = ov20; os = os20; oe = oe20; od = longint'(od20); end
            chk("out_valid", d, longint'(ov), longint'(ep[d][2].vld));
            chk("seq_err",   d, longint'(oe), longint'(ep[d][2].err));
            chk("out_data",  d, od, ep[d][2].data);
            if (ep[d][2].vld) chk("out_sat", d, longint'(os), longint'(ep[d][2].sat));
            if (ov) got_q[d].push_back('{data: od, sat: os});
            if (oe) n_errp[d]++;
        end
    endtask

    task automatic cycle(input bit v, input bit f, input bit l);
        in_valid = v; in_first = f; in_last = l;
        build(!v);
        model_beat(v, f, l);
        @(posedge clk); #1;
        cyc++;
        check_outputs();
    endtask

    task automatic flush();
        repeat (4) cycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            m_acc[d] = 0; m_hold[d] = 0; m_in[d] = 1'b0; m_sat[d] = 1'b0;
            for (int s = 0; s < 3; s++) ep[d][s] = '{vld: 1'b0, data: 0, sat: 1'b0, err: 1'b0};
        end
    endtask

    task automatic do_reset();
        reset = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        model_clear();
        #4;
        check_outputs();
        chk("rst_out_sat24", 0, longint'(os24), 0);
        chk("rst_out_sat20", 1, longint'(os20), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        check_outputs();
    endtask

    task automatic clear();
        for (int d = 0; d < 2; d++) begin got_q[d].delete(); n_errp[d] = 0; end
    endtask

    task automatic take(input string nm, input int d, input longint want, input bit want_sat);
        got_t g;
        chk({nm, "_present"}, d, longint'(got_q[d].size() > 0), 1);
        if (got_q[d].size() > 0) begin
            g = got_q[d].pop_front();
            chk(nm, d, g.data, want);
            chk({nm, "_sat"}, d, longint'(g.sat), longint'(want_sat));
        end
    endtask

    task automatic done(input string nm, input int errs);
        for (int d = 0; d < 2; d++) begin
            chk({nm, "_extra"}, d, longint'(got_q[d].size()), 0);
            chk({nm, "_errs"}, d, longint'(n_errp[d]), longint'(errs));
        end
    endtask

    initial begin
        vec_t tbl [8];
        tbl = '{'{0, 0, 0}, '{-128, -128, 147456}, '{-128, 127, -146304}, '{127, -128, -146304},
                '{5, 7, 315}, '{1, 1, 9}, '{127, 127, 145161}, '{-1, 1, -9}};

        reset = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        bcast(0, 0); build(1'b1);
        #2;
        do_reset();

        // Single-beat frames from the table, back to back.
        clear();
        foreach (tbl[n]) begin bcast(tbl[n].a, tbl[n].b); cycle(1'b1, 1'b1, 1'b1); end
        flush();
        foreach (tbl[n]) for (int d = 0; d < 2; d++) take("tbl", d, tbl[n].exp, 1'b0);
        done("tbl", 0);

        // Three beats of 5*7 separated by bubbles.
        clear(); bcast(5, 7);
        cycle(1'b1, 1'b1, 1'b0); cycle(1'b0, 1'b0, 1'b0); cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0); cycle(1'b0, 1'b0, 1'b0); cycle(1'b1, 1'b0, 1'b1);
        flush();
        take("bubble_frame", 0, 945, 1'b0); take("bubble_frame", 1, 945, 1'b0);
        done("bubble_frame", 0);

        // Positive saturation on the narrow accumulator, then a clean frame.
        clear(); bcast(-128, -128);
        for (int i = 0; i < 8; i++) cycle(1'b1, i == 0, i == 7);
        bcast(1, 1); cycle(1'b1, 1'b1, 1'b1);
        flush();
        take("sat_pos", 0, 1179648, 1'b0); take("sat_pos", 1, 524287, 1'b1);
        take("after_sat", 0, 9, 1'b0);     take("after_sat", 1, 9, 1'b0);
        done("sat_pos", 0);

        // Negative saturation.
        clear(); bcast(-128, 127);
        for (int i = 0; i < 8; i++) cycle(1'b1, i == 0, i == 7);
        flush();
        take("sat_neg", 0, -1170432, 1'b0); take("sat_neg", 1, -524288, 1'b1);
        done("sat_neg", 0);

        // Sat flag stays set after the clamped sum comes back into range.
        clear(); bcast(-128, -128);
        for (int i = 0; i < 4; i++) cycle(1'b1, i == 0, 1'b0);
        bcast(-128, 127); cycle(1'b1, 1'b0, 1'b1);
        flush();
        take("sticky", 0, 443520, 1'b0); take("sticky", 1, 377983, 1'b1);
        done("sticky", 0);

        // New first mid-frame discards the partial sum.
        clear(); bcast(5, 7);
        cycle(1'b1, 1'b1, 1'b0); cycle(1'b1, 1'b0, 1'b0);
        bcast(1, 1);
        cycle(1'b1, 1'b1, 1'b0); cycle(1'b1, 1'b0, 1'b1);
        flush();
        take("restart", 0, 18, 1'b0); take("restart", 1, 18, 1'b0);
        done("restart", 1);

        // Beat without first while idle is taken as a first.
        clear(); bcast(2, 3);
        cycle(1'b1, 1'b0, 1'b1);
        flush();
        take("no_first", 0, 54, 1'b0); take("no_first", 1, 54, 1'b0);
        done("no_first", 1);

        // Random lanes and framing.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 9; i++) begin
                la[i] = int'($urandom_range(255)) - 128;
                lb[i] = int'($urandom_range(255)) - 128;
            end
            cycle($urandom_range(3) != 0, $urandom_range(4) == 0, $urandom_range(3) == 0);
        end
        bcast(0, 0); cycle(1'b1, 1'b0, 1'b1);
        flush();

        // Every operand pair as a single-beat frame.
        clear();
        for (int a = -128; a < 128; a++)
            for (int b = -128; b < 128; b++) begin bcast(a, b); cycle(1'b1, 1'b1, 1'b1); end
        flush();
        chk("sweep_count", 0, longint'(got_q[0].size()), 65536);
        chk("sweep_count", 1, longint'(got_q[1].size()), 65536);

        // Reset in the middle of a frame.
        clear(); bcast(3, 3);
        cycle(1'b1, 1'b1, 1'b0); cycle(1'b1, 1'b0, 1'b0);
        do_reset();
        repeat (5) cycle(1'b0, 1'b0, 1'b0);
        chk("rst_no_valid", 0, longint'(got_q[0].size()), 0);
        chk("rst_no_valid", 1, longint'(got_q[1].size()), 0);
        bcast(4, 4); cycle(1'b1, 1'b1, 1'b1);
        flush();
        take("after_rst", 0, 144, 1'b0); take("after_rst", 1, 144, 1'b0);
        done("after_rst", 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pp_column_accumulator.md
Name: pp_column_accumulator

Overview:
- Sits directly downstream of `multiplier`, the 9-lane signed 8x8 partial-product generator.
- Consumes its 16 column-bit bundles, popcounts each column and forms the weighted sum plus the sign-correction constant, giving the 19-bit signed dot product of the 9 pairs.
- Optionally accumulates consecutive dot products (kernel depth / channels) into one saturating result for the downstream activation stage.
- Fully pipelined: one beat per clock, no backpressure.

Parameters:
- ACC_W, 24: accumulator/result width, signed; legal range 19..32.
- CORR, 19'h1D000: sign-extension correction constant added to the column sum.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  column bundle valid this cycle.
- in_first  in  1  beat starts a new accumulation.
- in_last  in  1  beat ends the accumulation.
- O15, O14, O1  in  9 each  single-row columns 15, 14, 1.
- O13, O12, O3, O0  in  18 each  two-row columns.
- O11, O10, O9, O8, O7, O4  in  36 each  four-row columns.
- O6  in  45  five-row column 6.
- O5, O2  in  27 each  three-row columns.
- out_valid  out  1  result valid, 1-cycle pulse.
- out_data  out  ACC_W  signed accumulated result.
- out_sat  out  1  result saturated; valid with out_valid.
- seq_err  out  1  1-cycle pulse on a first/last framing violation.

Behaviour:
- Reset (async assert, sync release): all valid bits, out_valid, out_sat and seq_err are 0; out_data is 0; FSM is IDLE; accumulator is 0.
- S1 (cycle t+1): register the popcount Oa[k] of every column, 6 bits each (max 45), together with valid/first/last.
- S2 (t+2): dot = sum over k of (Oa[k] << k) + CORR, truncated to 19 bits and read as signed.
  - Range is -146304..147456. No overflow is possible.
- S3 (t+3): the accumulator FSM.
  - Sign-extend dot to ACC_W+1 bits and add it to the accumulator, or load it on first.
  - Saturate to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - The sat flag is sticky for the current frame.
- FSM states IDLE and ACCUM:
  - IDLE + valid + first + !last: acc = dot, go to ACCUM.
  - IDLE + valid + first + last: emit dot (saturated to ACC_W), stay in IDLE.
  - IDLE + valid + !first: treat as first, pulse seq_err, then follow the matching first rule above.
  - ACCUM + valid + !first + !last: acc = acc + dot.
  - ACCUM + valid + last: emit acc + dot with the sat flag, go to IDLE.
  - ACCUM + valid + first: discard the partial sum, pulse seq_err, restart as in IDLE with first.
- Invalid cycles (bubbles) carry nothing, leave the accumulator unchanged and hold the FSM state.
- Latency: out_valid rises exactly 3 cycles after the in_valid beat carrying in_last.
  - out_data holds its value until the next emit.
- Reset mid-frame: the partial sum and in-flight beats are dropped; no out_valid follows reset deassertion.
- Column inputs are ignored when in_valid is 0.

Decomposition:
- Package pp_acc_pkg holds:
  - CORR_DEFAULT = 19'h1D000;
  - the column row-count constants (1,1,2,2,4,4,4,4,4,5,3,4,2,3,1,2 for columns 15..0);
  - DOT_W = 19, POP_W = 6;
  - FSM state encoding IDLE=1'b0, ACCUM=1'b1.
- Sub-module col_popcount, parameter ROWS (1..5), input 9*ROWS bits, output 6-bit count. Instantiated 16 times in S1.

Test Plan:
- The bench drives the upstream `multiplier` with a broadcast multiplicand/multiplier pair.
- Single frame 0*0 (first=last=1) -> out_valid at t+3, out_data=0, out_sat=0, seq_err=0.
- Single frame (-128)*(-128) -> out_data=147456; (-128)*127 -> out_data=-146304.
- Frame of 3 beats of 5*7, with bubbles between beats -> exactly one out_valid, 3 cycles after last, out_data=945.
- ACC_W=20, frame of 8 beats of (-128)*(-128) -> out_data=524287, out_sat=1.
  - Next frame 1*1 single beat -> out_data=9, out_sat=0.
- first, beat, then a new first mid-frame -> seq_err pulse; the partial sum is discarded and the result equals the second frame only.
  - A !first beat in IDLE -> seq_err pulse and is treated as first.
- Exhaustive sweep of all 65536 pairs, single-beat frames, back-to-back -> every out_data equals 9*a*b.
  - Then assert reset mid-frame for 1 cycle -> no out_valid, outputs 0, and the next frame is correct.
